// File: rtl/d_ip_timer_core_if.sv
// Register-field and event bundle between the timer register file and the counting engine.
// The master side drives the decoded CTRL/CNT_* fields; the slave side is the counting engine.
interface d_ip_timer_core_if #(parameter int SIZE = 8);
  logic            mod_en;
  logic            cnt_en;
  logic            dir;
  logic            one_shot;
  logic            clk_sel;
  logic            timer_in;
  logic            load;
  logic [SIZE-1:0] cnt_init;
  logic [SIZE-1:0] cnt_min;
  logic [SIZE-1:0] cnt_max;
  logic [SIZE-1:0] cnt_m0;
  logic [SIZE-1:0] cnt_m1;
  logic [SIZE-1:0] cnt;
  logic            overflow_int;
  logic            comp_0_match_int;
  logic            comp_1_match_int;
  logic            timer_out;
  logic            trigger;
  logic            busy;

  modport master (
    output mod_en, cnt_en, dir, one_shot, clk_sel, timer_in, load,
           cnt_init, cnt_min, cnt_max, cnt_m0, cnt_m1,
    input  cnt, overflow_int, comp_0_match_int, comp_1_match_int,
           timer_out, trigger, busy
  );

  modport slave (
    input  mod_en, cnt_en, dir, one_shot, clk_sel, timer_in, load,
           cnt_init, cnt_min, cnt_max, cnt_m0, cnt_m1,
    output cnt, overflow_int, comp_0_match_int, comp_1_match_int,
           timer_out, trigger, busy
  );
endinterface

// File: rtl/d_ip_timer_core.sv
// Timer counting engine: up/down counter with bounds, compare matches, PWM level and one-shot trigger.
//   state   | meaning
//   S_IDLE  | stopped, waiting for mod_en & cnt_en (reloads cnt_init on start)
//   S_RUN   | counting on each tick
//   S_PAUSE | cnt_en dropped mid-count, cnt held, resume without reload
//   S_DONE  | one-shot reached its bound, cnt held until cnt_en clears
module d_ip_timer_core #(
  parameter int SIZE = 8
) (
  input logic               clk,
  input logic               rst_b,
  d_ip_timer_core_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [SIZE-1:0] cnt_q, cnt_nxt;
  logic            ovf_q, c0_q, c1_q, tout_q, trig_q;
  logic            sync1, sync2, sync_prev, ext_tick;
  logic            tick, adv, term, stop, m0_hit, m1_hit, busy;

  always_ff @(posedge clk) begin
    if (!rst_b) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!bus.mod_en) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (bus.cnt_en)  state_nxt = S_RUN;
        S_RUN:   if (!bus.cnt_en) state_nxt = S_PAUSE;
                 else if (stop)   state_nxt = S_DONE;
        S_PAUSE: if (bus.cnt_en)  state_nxt = S_RUN;
        S_DONE:  if (!bus.cnt_en) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Load wins over a tick, so a loaded cycle never advances, wraps or pulses.
  always_comb begin
    tick = bus.clk_sel ? ext_tick : 1'b1;
    adv  = (state == S_RUN) && bus.mod_en && bus.cnt_en && tick && !bus.load;
    term = bus.dir ? (cnt_q == bus.cnt_min) : (cnt_q == bus.cnt_max);
    stop = adv && term && bus.one_shot;
    busy = (state == S_RUN);
    cnt_nxt = cnt_q;
    if (bus.load || (state == S_IDLE && bus.mod_en && bus.cnt_en)) begin
      cnt_nxt = bus.cnt_init;
    end else if (adv) begin
      if (term) begin
        if (!bus.one_shot) cnt_nxt = bus.dir ? bus.cnt_max : bus.cnt_min;
      end else begin
        cnt_nxt = bus.dir ? (cnt_q - SIZE'(1)) : (cnt_q + SIZE'(1));
      end
    end
    m0_hit = adv && !stop && (cnt_nxt == bus.cnt_m0);
    m1_hit = adv && !stop && (cnt_nxt == bus.cnt_m1);
  end

  // Extra registered stage after the edge detector sets the timer_in rise-to-update latency to 3 clocks.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
      ext_tick  <= 1'b0;
    end else begin
      sync1     <= bus.timer_in;
      sync2     <= sync1;
      sync_prev <= sync2;
      ext_tick  <= sync2 & ~sync_prev;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      c0_q   <= 1'b0;
      c1_q   <= 1'b0;
      tout_q <= 1'b0;
      trig_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_nxt;
      ovf_q  <= adv && term;
      trig_q <= stop;
      c0_q   <= m0_hit;
      c1_q   <= m1_hit;
      if (m0_hit && m1_hit) tout_q <= ~tout_q;
      else if (m0_hit)      tout_q <= 1'b1;
      else if (m1_hit)      tout_q <= 1'b0;
    end
  end

  assign bus.cnt              = cnt_q;
  assign bus.overflow_int     = ovf_q;
  assign bus.comp_0_match_int = c0_q;
  assign bus.comp_1_match_int = c1_q;
  assign bus.timer_out        = tout_q;
  assign bus.trigger          = trig_q;
  assign bus.busy             = busy;

endmodule

// File: doc/d_ip_timer_core.md
Name: d_ip_timer_core

Overview:
Counting engine of the timer IP. It sits between the register file and the interrupt/output logic. It takes the decoded CTRL/CNT_* register fields and advances the counter on internal or external ticks. It produces the cnt value, overflow/compare interrupt pulses, timer_out and trigger, which the SVA checker monitors directly.

Parameters:
SIZE, 8, counter and compare-value width

Ports:
clk  input  1  system clock
rst_b  input  1  synchronous active-low reset
mod_en  input  1  module enable; 0 forces IDLE
cnt_en  input  1  CTRL[0], run request
dir  input  1  CTRL[1], 0=up, 1=down
one_shot  input  1  CTRL[2], 0=free-run wrap, 1=stop at terminal count
clk_sel  input  1  CTRL[3], 0=tick every clk, 1=tick on timer_in rising edge
timer_in  input  1  asynchronous external tick input
load  input  1  single-cycle pulse: cnt <= cnt_init
cnt_init  input  SIZE  start value
cnt_min  input  SIZE  lower bound
cnt_max  input  SIZE  upper bound
cnt_m0  input  SIZE  compare 0 value
cnt_m1  input  SIZE  compare 1 value
cnt  output  SIZE  current count
overflow_int  output  1  terminal-count pulse
comp_0_match_int  output  1  compare 0 pulse
comp_1_match_int  output  1  compare 1 pulse
timer_out  output  1  PWM-style output level
trigger  output  1  one-shot completion pulse
busy  output  1  high in RUN

Behaviour:
- Reset (rst_b=0 at posedge clk):
  - cnt=0; every output 0.
  - FSM=IDLE; timer_in synchroniser and edge flops=0.
- Tick generation:
  - clk_sel=0: tick=1 every cycle.
  - clk_sel=1: timer_in passes a 2-flop synchroniser, then a rising-edge detector (sync2 & ~prev).
  - A timer_in rise sampled at edge k updates cnt at edge k+3.
  - Ticks are ignored outside RUN.
- FSM states: IDLE, RUN, PAUSE, DONE.
  - Any state, mod_en=0 -> IDLE. cnt and timer_out hold; pulses 0.
  - IDLE, mod_en&cnt_en -> RUN. cnt<=cnt_init on the same edge.
  - RUN, cnt_en=0 -> PAUSE. cnt holds.
  - PAUSE, cnt_en=1 -> RUN. No reload.
  - RUN, terminal count with one_shot=1 -> DONE.
  - DONE, cnt_en=0 -> IDLE. While in DONE, cnt holds the terminal value.
- load=1: cnt<=cnt_init in any state. Load has priority over a tick in the same cycle. Load produces no match or overflow pulse and does not change state.
- Counting on tick in RUN, up (dir=0):
  - cnt==cnt_max: terminal event.
  - Otherwise cnt+1, modulo 2^SIZE.
- Counting on tick in RUN, down (dir=1):
  - cnt==cnt_min: terminal event.
  - Otherwise cnt-1, modulo 2^SIZE.
- Terminal event:
  - overflow_int=1 for exactly one cycle, registered on the update edge.
  - free-run: cnt<=cnt_min (up) or cnt_max (down).
  - one_shot: cnt holds the bound, trigger=1 for one cycle, go to DONE.
- Out-of-range cnt:
  - Bounds are checked by equality only.
  - If cnt lies outside [cnt_min,cnt_max], counting continues with wrap modulo 2^SIZE until a bound is hit.
  - cnt_min>cnt_max is legal; the same rule applies.
- Compare matches:
  - comp_0_match_int=1 for one cycle when a tick update writes a new cnt equal to cnt_m0.
  - comp_1_match_int behaves the same for cnt_m1.
  - A wrap value equal to m0/m1 also matches.
  - Pulses are registered together with the cnt update.
- timer_out:
  - m0 match sets it to 1; m1 match clears it to 0.
  - Simultaneous m0 and m1 match (cnt_m0==cnt_m1): toggle.
  - Holds otherwise.
- Simultaneous events: overflow and match pulses can assert in the same cycle.
- busy = (state==RUN), registered.
- Reset mid-count: all state returns to reset values on the next edge; no pulse is emitted.

Test Plan:
1. Reset value check: hold rst_b=0 for 2 clocks -> cnt=0x00, all outputs 0, busy=0.
2. Up free-run: init=0xFC, min=0x10, max=0xFE, clk_sel=0, cnt_en=1 -> cnt sequence FC,FD,FE,10. overflow_int pulses once, on the edge cnt becomes 0x10. trigger stays 0.
3. Down one-shot: init=0x05, min=0x02, dir=1, one_shot=1 -> cnt 05,04,03,02, then holds 0x02. overflow_int and trigger pulse once together; busy drops. Clearing cnt_en returns the FSM to IDLE.
4. Compare / timer_out: m0=0x03, m1=0x06, init=0, max=0x07 -> timer_out rises at cnt=3, falls at cnt=6, and repeats each wrap. With m0=m1=0x04, timer_out toggles each time cnt reaches 4.
5. External tick: clk_sel=1; drive 3 timer_in pulses, each 4 clocks wide -> cnt advances exactly 3, each update 3 clocks after the rise is sampled. No advance while timer_in is held high.
6. Pause/load priority: deassert cnt_en mid-count at cnt=0x20 -> cnt holds 0x20, reassert resumes at 0x21. Then pulse load with a tick in the same cycle -> cnt=cnt_init, no match pulse. Then drive mod_en=0 -> FSM goes to IDLE.
